// File: rtl/register_file_mp_pkg.sv
// rtl/register_file_mp_pkg.sv - shared constants and helpers for register_file_mp
package register_file_mp_pkg;

    localparam logic [1:0] SRC_ZERO  = 2'd0;
    localparam logic [1:0] SRC_BYP_A = 2'd1;
    localparam logic [1:0] SRC_BYP_B = 2'd2;
    localparam logic [1:0] SRC_MEM   = 2'd3;

    function automatic int addr_w(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - read-source mux with optional output register
module rf_read_port
    import register_file_mp_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit READ_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       src_sel,
    input  logic [WIDTH-1:0] byp_a_data,
    input  logic [WIDTH-1:0] byp_b_data,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             mem_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out
);

    logic [WIDTH-1:0] data_sel;
    logic             valid_sel;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_comb begin
        data_sel  = '0;
        valid_sel = 1'b0;
        case (src_sel)
            SRC_ZERO: begin
                data_sel  = '0;
                valid_sel = 1'b1;
            end
            SRC_BYP_A: begin
                data_sel  = byp_a_data;
                valid_sel = 1'b1;
            end
            SRC_BYP_B: begin
                data_sel  = byp_b_data;
                valid_sel = 1'b1;
            end
            default: begin
                data_sel  = mem_data;
                valid_sel = mem_valid;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_sel;
            valid_q <= valid_sel;
        end
    end

    assign data_out  = READ_REG ? data_q  : data_sel;
    assign valid_out = READ_REG ? valid_q : valid_sel;

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - two-read, two-write register file with valid tracking
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter bit ZERO_REG = 1'b0,
    parameter bit READ_REG = 1'b0,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Write_Enable_A,
    input  logic [ADDR_W-1:0] Write_Addr_A,
    input  logic [WIDTH-1:0]  Data_In_A,
    input  logic              Write_Enable_B,
    input  logic [ADDR_W-1:0] Write_Addr_B,
    input  logic [WIDTH-1:0]  Data_In_B,
    input  logic              Clear_Valid,
    input  logic [ADDR_W-1:0] Read_Addr_1,
    input  logic [ADDR_W-1:0] Read_Addr_2,
    output logic [WIDTH-1:0]  Data_Out_1,
    output logic [WIDTH-1:0]  Data_Out_2,
    output logic              Valid_Out_1,
    output logic              Valid_Out_2
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             wr_a_ok;
    logic             wr_b_ok;
    logic [1:0]       src_1;
    logic [1:0]       src_2;

    assign wr_a_ok = Write_Enable_A && !(ZERO_REG && (Write_Addr_A == '0));
    assign wr_b_ok = Write_Enable_B && !(ZERO_REG && (Write_Addr_B == '0));

    // Port A is applied last so it overwrites port B on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
        end else begin
            if (Clear_Valid) begin
                valid <= '0;
            end
            if (wr_b_ok) begin
                mem[Write_Addr_B]   <= Data_In_B;
                valid[Write_Addr_B] <= 1'b1;
            end
            if (wr_a_ok) begin
                mem[Write_Addr_A]   <= Data_In_A;
                valid[Write_Addr_A] <= 1'b1;
            end
        end
    end

    function automatic logic [1:0] read_src(input logic [ADDR_W-1:0] ra,
                                            input logic a_ok, input logic [ADDR_W-1:0] wa,
                                            input logic b_ok, input logic [ADDR_W-1:0] wb);
        if (ZERO_REG && (ra == '0)) begin
            return SRC_ZERO;
        end else if (BYPASS && a_ok && (wa == ra)) begin
            return SRC_BYP_A;
        end else if (BYPASS && b_ok && (wb == ra)) begin
            return SRC_BYP_B;
        end
        return SRC_MEM;
    endfunction

    assign src_1 = read_src(Read_Addr_1, wr_a_ok, Write_Addr_A, wr_b_ok, Write_Addr_B);
    assign src_2 = read_src(Read_Addr_2, wr_a_ok, Write_Addr_A, wr_b_ok, Write_Addr_B);

    rf_read_port #(.WIDTH(WIDTH), .READ_REG(READ_REG)) u_read_1 (
        .clk        (clk),
        .rst        (rst),
        .src_sel    (src_1),
        .byp_a_data (Data_In_A),
        .byp_b_data (Data_In_B),
        .mem_data   (mem[Read_Addr_1]),
        .mem_valid  (valid[Read_Addr_1]),
        .data_out   (Data_Out_1),
        .valid_out  (Valid_Out_1)
    );

    rf_read_port #(.WIDTH(WIDTH), .READ_REG(READ_REG)) u_read_2 (
        .clk        (clk),
        .rst        (rst),
        .src_sel    (src_2),
        .byp_a_data (Data_In_A),
        .byp_b_data (Data_In_B),
        .mem_data   (mem[Read_Addr_2]),
        .mem_valid  (valid[Read_Addr_2]),
        .data_out   (Data_Out_2),
        .valid_out  (Valid_Out_2)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - randomized and directed bench over four configurations
module tb_register_file_mp;

    logic       clk = 1'b1;
    logic       rst;
    logic       we_a, we_b, clr;
    logic [3:0] wa_a, wa_b, ra1, ra2;
    logic [7:0] da_a, da_b;

    logic [7:0] dout1 [4];
    logic [7:0] dout2 [4];
    logic       v1 [4];
    logic       v2 [4];

    // cfg: 0 comb/bypass, 1 zero/comb/old, 2 zero/reg/bypass, 3 reg/old
    bit zr_cfg [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit rr_cfg [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit bp_cfg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    logic [7:0] m_data  [4][16];
    logic       m_valid [4][16];
    logic [8:0] pend [4][2];
    bit         known [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_file_mp #(.ZERO_REG(1'b0), .READ_REG(1'b0), .BYPASS(1'b1)) dut0 (
        .clk(clk), .rst(rst),
        .Write_Enable_A(we_a), .Write_Addr_A(wa_a), .Data_In_A(da_a),
        .Write_Enable_B(we_b), .Write_Addr_B(wa_b), .Data_In_B(da_b),
        .Clear_Valid(clr), .Read_Addr_1(ra1), .Read_Addr_2(ra2),
        .Data_Out_1(dout1[0]), .Data_Out_2(dout2[0]), .Valid_Out_1(v1[0]), .Valid_Out_2(v2[0]));

    register_file_mp #(.ZERO_REG(1'b1), .READ_REG(1'b0), .BYPASS(1'b0)) dut1 (
        .clk(clk), .rst(rst),
        .Write_Enable_A(we_a), .Write_Addr_A(wa_a), .Data_In_A(da_a),
        .Write_Enable_B(we_b), .Write_Addr_B(wa_b), .Data_In_B(da_b),
        .Clear_Valid(clr), .Read_Addr_1(ra1), .Read_Addr_2(ra2),
        .Data_Out_1(dout1[1]), .Data_Out_2(dout2[1]), .Valid_Out_1(v1[1]), .Valid_Out_2(v2[1]));

    register_file_mp #(.ZERO_REG(1'b1), .READ_REG(1'b1), .BYPASS(1'b1)) dut2 (
        .clk(clk), .rst(rst),
        .Write_Enable_A(we_a), .Write_Addr_A(wa_a), .Data_In_A(da_a),
        .Write_Enable_B(we_b), .Write_Addr_B(wa_b), .Data_In_B(da_b),
        .Clear_Valid(clr), .Read_Addr_1(ra1), .Read_Addr_2(ra2),
        .Data_Out_1(dout1[2]), .Data_Out_2(dout2[2]), .Valid_Out_1(v1[2]), .Valid_Out_2(v2[2]));

    register_file_mp #(.ZERO_REG(1'b0), .READ_REG(1'b1), .BYPASS(1'b0)) dut3 (
        .clk(clk), .rst(rst),
        .Write_Enable_A(we_a), .Write_Addr_A(wa_a), .Data_In_A(da_a),
        .Write_Enable_B(we_b), .Write_Addr_B(wa_b), .Data_In_B(da_b),
        .Clear_Valid(clr), .Read_Addr_1(ra1), .Read_Addr_2(ra2),
        .Data_Out_1(dout1[3]), .Data_Out_2(dout2[3]), .Valid_Out_1(v1[3]), .Valid_Out_2(v2[3]));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected {valid, data} seen by a read of address a under configuration c.
    function automatic logic [8:0] model_read(input int c, input logic [3:0] a);
        if (zr_cfg[c] && a == 4'd0) return 9'h100;
        if (bp_cfg[c] && we_a && wa_a == a) return {1'b1, da_a};
        if (bp_cfg[c] && we_b && wa_b == a && !(zr_cfg[c] && wa_b == 4'd0)) return {1'b1, da_b};
        return {m_valid[c][a], m_data[c][a]};
    endfunction

    task automatic settle();
        logic [8:0] got, exp;
        logic [3:0] ra;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 2; p++) begin
                ra  = (p == 0) ? ra1 : ra2;
                got = (p == 0) ? {v1[c], dout1[c]} : {v2[c], dout2[c]};
                exp = model_read(c, ra);
                if (rr_cfg[c]) begin
                    if (known[c]) check($sformatf("cfg%0d_port%0d", c, p + 1), 16'(got), 16'(pend[c][p]));
                    pend[c][p] = rst ? 9'h000 : exp;
                end else if (!rst) begin
                    check($sformatf("cfg%0d_port%0d", c, p + 1), 16'(got), 16'(exp));
                end
            end
            if (rst) known[c] = 1'b1;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
            if (rst) begin
                for (int i = 0; i < 16; i++) begin
                    m_data[c][i]  = 8'h00;
                    m_valid[c][i] = 1'b0;
                end
            end else begin
                if (clr) for (int i = 0; i < 16; i++) m_valid[c][i] = 1'b0;
                if (we_b && !(zr_cfg[c] && wa_b == 4'd0)) begin
                    m_data[c][wa_b]  = da_b;
                    m_valid[c][wa_b] = 1'b1;
                end
                if (we_a && !(zr_cfg[c] && wa_a == 4'd0)) begin
                    m_data[c][wa_a]  = da_a;
                    m_valid[c][wa_a] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we_a = 1'b0; we_b = 1'b0; clr = 1'b0;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    initial begin
        rst = 1'b1; we_a = 1'b0; we_b = 1'b0; clr = 1'b0;
        wa_a = 4'd0; wa_b = 4'd0; da_a = 8'h00; da_b = 8'h00; ra1 = 4'd0; ra2 = 4'd1;
        step();
        idle();
        step();

        // Fill all entries through port A, reading back one cycle behind.
        for (int i = 0; i < 17; i++) begin
            we_a = (i < 16);
            wa_a = 4'(i);
            da_a = 8'h01 << (i % 8);
            ra1  = 4'(i - 1);
            ra2  = 4'(i);
            step();
        end
        idle();
        ra1 = 4'd15; ra2 = 4'd8;
        settle();
        check("fill_e15", 16'({v1[0], dout1[0]}), 16'h180);
        check("fill_e8", 16'({v2[0], dout2[0]}), 16'h101);
        advance();
        rst = 1'b1;
        step();
        idle();
        for (int i = 0; i < 16; i += 2) begin
            ra1 = 4'(i); ra2 = 4'(i + 1);
            step();
        end

        // Collision on address 5.
        we_a = 1'b1; wa_a = 4'd5; da_a = 8'hAA;
        we_b = 1'b1; wa_b = 4'd5; da_b = 8'h55;
        step();
        idle(); ra1 = 4'd5;
        settle();
        check("collision", 16'({v1[0], dout1[0]}), 16'h1AA);
        advance();

        // Dual write.
        we_a = 1'b1; wa_a = 4'd3; da_a = 8'h11;
        we_b = 1'b1; wa_b = 4'd9; da_b = 8'h22;
        step();
        idle(); ra1 = 4'd3; ra2 = 4'd9;
        settle();
        check("dual_p1", 16'({v1[0], dout1[0]}), 16'h111);
        check("dual_p2", 16'({v2[0], dout2[0]}), 16'h122);
        advance();

        // Bypass on entry 7.
        we_a = 1'b1; wa_a = 4'd7; da_a = 8'h33;
        step();
        we_a = 1'b1; wa_a = 4'd7; da_a = 8'h44; ra1 = 4'd7;
        settle();
        check("byp_comb_new", 16'(dout1[0]), 16'h44);
        check("byp_comb_old", 16'(dout1[1]), 16'h33);
        advance();
        idle(); ra1 = 4'd7;
        settle();
        check("byp_reg_new", 16'(dout1[2]), 16'h44);
        check("byp_reg_old", 16'(dout1[3]), 16'h33);
        advance();

        // Writes to address 0 against the zero register.
        we_a = 1'b1; wa_a = 4'd0; da_a = 8'hFF;
        we_b = 1'b1; wa_b = 4'd0; da_b = 8'hFF; ra1 = 4'd0;
        settle();
        check("zero_same_cycle", 16'({v1[1], dout1[1]}), 16'h100);
        advance();
        idle(); ra1 = 4'd0;
        settle();
        check("zero_comb_after", 16'({v1[1], dout1[1]}), 16'h100);
        check("zero_reg_after", 16'({v1[2], dout1[2]}), 16'h100);
        check("nonzero_reg0", 16'({v1[0], dout1[0]}), 16'h1FF);
        advance();

        // Clear_Valid together with a write.
        we_a = 1'b1; wa_a = 4'd4; da_a = 8'h77;
        step();
        idle(); clr = 1'b1; we_a = 1'b1; wa_a = 4'd2; da_a = 8'h5A;
        step();
        idle(); ra1 = 4'd2; ra2 = 4'd4;
        settle();
        check("clr_kept", 16'({v1[0], dout1[0]}), 16'h15A);
        check("clr_cleared", 16'({v2[0], dout2[0]}), 16'h077);
        advance();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 99) == 0);
            clr  = ($urandom_range(0, 19) == 0);
            we_a = $urandom_range(0, 1);
            we_b = $urandom_range(0, 1);
            wa_a = 4'($urandom_range(0, 15));
            wa_b = ($urandom_range(0, 3) == 0) ? wa_a : 4'($urandom_range(0, 15));
            da_a = 8'($urandom);
            da_b = 8'($urandom);
            ra1  = ($urandom_range(0, 2) == 0) ? wa_a : 4'($urandom_range(0, 15));
            ra2  = ($urandom_range(0, 2) == 0) ? wa_b : 4'($urandom_range(0, 15));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
